// File: rtl/la_pwrseq.sv
// la_pwrseq: power-domain sequencer for one switchable domain.
// Isolation always brackets power-switch and domain-reset changes.
module la_pwrseq #(
  parameter int ISO_CYCLES = 4,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 256,
  parameter int RET        = 1,
  parameter int CW         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pwr_req,
  input  logic pwr_ack,
  input  logic err_clr,
  output logic pwr_en,
  output logic iso,
  output logic dom_reset,
  output logic save,
  output logic restore,
  output logic busy,
  output logic on,
  output logic err
);

  typedef enum logic [3:0] {
    OFF, PU_SW, PU_RES, PU_RST, PU_ISO,
    ON, PD_ISO, PD_SAV, PD_RST, PD_SW
  } state_t;

  localparam logic [CW-1:0] ISO_LAST = CW'(ISO_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          tmo;
  logic          pen_d;
  logic          iso_d;
  logic          rst_d;

  always_comb begin
    nxt = state;
    tmo = 1'b0;
    unique case (state)
      OFF:    if (pwr_req) nxt = PU_SW;
      PU_SW: begin
        // a timed-out ack is treated as if the rail came up
        if (pwr_ack || cnt == TO_LAST) begin
          nxt = (RET != 0) ? PU_RES : PU_RST;
          tmo = !pwr_ack;
        end
      end
      PU_RES: nxt = PU_RST;
      PU_RST: if (cnt == RST_LAST) nxt = PU_ISO;
      PU_ISO: if (cnt == ISO_LAST) nxt = ON;
      ON:     if (!pwr_req) nxt = PD_ISO;
      PD_ISO: begin
        if (cnt == ISO_LAST)
          nxt = (RET != 0) ? PD_SAV : PD_RST;
      end
      PD_SAV: nxt = PD_RST;
      PD_RST: nxt = PD_SW;
      PD_SW: begin
        if (!pwr_ack || cnt == TO_LAST) begin
          nxt = OFF;
          tmo = pwr_ack;
        end
      end
      default: nxt = OFF;
    endcase
  end

  always_comb begin
    pen_d = !(nxt == OFF || nxt == PD_SW);
    iso_d = (nxt != ON);
    rst_d = !(nxt == PU_ISO || nxt == ON ||
              nxt == PD_ISO || nxt == PD_SAV);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      cnt       <= '0;
      pwr_en    <= 1'b0;
      iso       <= 1'b1;
      dom_reset <= 1'b1;
      save      <= 1'b0;
      restore   <= 1'b0;
      busy      <= 1'b0;
      on        <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      pwr_en    <= pen_d;
      iso       <= iso_d;
      dom_reset <= rst_d;
      save      <= (nxt == PD_SAV);
      restore   <= (nxt == PU_RES);
      busy      <= !(nxt == OFF || nxt == ON);
      on        <= (nxt == ON);
      if (tmo)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_la_pwrseq.sv
// tb_la_pwrseq: scoreboard bench for la_pwrseq.
// Expected output vectors are queued per cycle and popped at negedge.
module tb_la_pwrseq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pwr_req = 1'b0;
  logic pwr_ack = 1'b0;
  logic err_clr = 1'b0;

  logic pen1, iso1, rst1, sav1, res1, busy1, on1, err1;
  logic pen0, iso0, rst0, sav0, res0, busy0, on0, err0;
  logic [7:0] o1, o0;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] e;

  // {pwr_en, iso, dom_reset, save, restore, busy, on, err}
  localparam logic [7:0] S_OFF   = 8'b0110_0000;
  localparam logic [7:0] S_PUSW  = 8'b1110_0100;
  localparam logic [7:0] S_PURES = 8'b1110_1100;
  localparam logic [7:0] S_PURST = 8'b1110_0100;
  localparam logic [7:0] S_PUISO = 8'b1100_0100;
  localparam logic [7:0] S_ON    = 8'b1000_0010;
  localparam logic [7:0] S_PDISO = 8'b1100_0100;
  localparam logic [7:0] S_PDSAV = 8'b1101_0100;
  localparam logic [7:0] S_PDRST = 8'b1110_0100;
  localparam logic [7:0] S_PDSW  = 8'b0110_0100;
  localparam logic [7:0] ERRB    = 8'b0000_0001;

  always #5 clk = ~clk;

  assign o1 = {pen1, iso1, rst1, sav1, res1, busy1, on1, err1};
  assign o0 = {pen0, iso0, rst0, sav0, res0, busy0, on0, err0};

  la_pwrseq #(
    .ISO_CYCLES(4), .RST_CYCLES(3), .TIMEOUT(8), .RET(1), .CW(16)
  ) u_ret (
    .clk(clk), .reset(reset), .pwr_req(pwr_req),
    .pwr_ack(pwr_ack), .err_clr(err_clr),
    .pwr_en(pen1), .iso(iso1), .dom_reset(rst1), .save(sav1),
    .restore(res1), .busy(busy1), .on(on1), .err(err1)
  );

  la_pwrseq #(
    .ISO_CYCLES(4), .RST_CYCLES(3), .TIMEOUT(8), .RET(0), .CW(16)
  ) u_noret (
    .clk(clk), .reset(reset), .pwr_req(pwr_req),
    .pwr_ack(pwr_ack), .err_clr(err_clr),
    .pwr_en(pen0), .iso(iso0), .dom_reset(rst0), .save(sav0),
    .restore(res0), .busy(busy0), .on(on0), .err(err0)
  );

  task automatic push(input logic [7:0] v, input int n);
    repeat (n) q.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pwr_req = 1'b0;
    pwr_ack = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o1 !== S_OFF || o0 !== S_OFF) begin
      errors++;
      $display("FAIL reset_vals got %b/%b exp %b", o1, o0, S_OFF);
    end
    push(S_OFF, 10);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (o1 !== e || o0 !== e) begin
        errors++;
        $display("FAIL idle_off c%0d got %b/%b exp %b", c, o1, o0, e);
      end
    end
  endtask

  task automatic test_power_up();
    do_reset();
    push(S_OFF, 1);
    push(S_PUSW, 3);
    push(S_PURES, 1);
    push(S_PURST, 3);
    push(S_PUISO, 4);
    push(S_ON, 2);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL power_up c%0d got %b exp %b", c, o1, e);
      end
      if (c == 0) pwr_req = 1'b1;
      if (c == 3) pwr_ack = 1'b1;
    end
  endtask

  // Continues from ON left by test_power_up.
  task automatic test_power_down();
    push(S_ON, 1);
    push(S_PDISO, 4);
    push(S_PDSAV, 1);
    push(S_PDRST, 1);
    push(S_PDSW, 3);
    push(S_OFF, 2);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL power_down c%0d got %b exp %b", c, o1, e);
      end
      if (c == 0) pwr_req = 1'b0;
      if (c == 9) pwr_ack = 1'b0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    push(S_OFF, 1);
    push(S_PUSW, 8);
    push(S_PURES | ERRB, 1);
    push(S_PURST | ERRB, 3);
    push(S_PUISO | ERRB, 4);
    push(S_ON | ERRB, 1);
    push(S_ON, 2);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL timeout c%0d got %b exp %b", c, o1, e);
      end
      if (c == 0) pwr_req = 1'b1;
      err_clr = (c == 17);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(S_OFF, 1);
    push(S_PUSW, 1);
    push(S_PURES, 1);
    push(S_PURST, 3);
    push(S_PUISO, 4);
    push(S_ON, 1);
    push(S_PDISO, 4);
    push(S_PDSAV, 1);
    push(S_PDRST, 1);
    push(S_PDSW, 1);
    push(S_OFF, 2);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL toggle c%0d got %b exp %b", c, o1, e);
      end
      if (c == 0) begin
        pwr_req = 1'b1;
        pwr_ack = 1'b1;
      end
      if (c == 4) pwr_req = 1'b0;
      if (c == 16) pwr_ack = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push(S_OFF, 1);
    push(S_PUSW, 1);
    push(S_PURES, 1);
    push(S_PURST, 3);
    push(S_PUISO, 1);
    push(S_OFF, 3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL mid_reset c%0d got %b exp %b", c, o1, e);
      end
      if (c == 0) begin
        pwr_req = 1'b1;
        pwr_ack = 1'b1;
      end
      if (c == 6) reset = 1'b1;
      if (c == 7) begin
        reset = 1'b0;
        pwr_req = 1'b0;
        pwr_ack = 1'b0;
      end
    end
  endtask

  task automatic test_no_ret();
    do_reset();
    push(S_OFF, 1);
    push(S_PUSW, 1);
    push(S_PURST, 3);
    push(S_PUISO, 4);
    push(S_ON, 1);
    push(S_PDISO, 4);
    push(S_PDRST, 1);
    push(S_PDSW, 1);
    push(S_OFF, 2);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (o0 !== e) begin
        errors++;
        $display("FAIL no_ret c%0d got %b exp %b", c, o0, e);
      end
      if (c == 0) begin
        pwr_req = 1'b1;
        pwr_ack = 1'b1;
      end
      if (c == 9) pwr_req = 1'b0;
      if (c == 14) pwr_ack = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    test_no_ret();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_pwrseq.md
Name: la_pwrseq

Overview:
- Power-domain sequencing controller for one switchable domain.
- Generates the isolation control that drives the domain's vectorized isolation cells (`iso` pin), plus the power-switch enable, domain reset and retention save/restore strobes.
- Orders every on/off transition so that isolation always brackets power and reset changes.
- Sits in the always-on domain, between the system power manager (level request) and the domain's switch/isolation/retention cells.

Parameters:
- ISO_CYCLES, 4: cycles isolation is held around reset release/assert (≥1).
- RST_CYCLES, 4: cycles domain reset is held after power-good/restore (≥1).
- TIMEOUT, 256: max cycles to wait for `pwr_ack` before flagging an error (≥1).
- RET, 1: 1 = generate save/restore strobes; 0 = skip the retention states.
- CW, 16: internal counter width; must hold max(ISO_CYCLES, RST_CYCLES, TIMEOUT).

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous active-high reset.
- pwr_req, input, 1: level request; 1 = domain on, 0 = domain off.
- pwr_ack, input, 1: power-switch status; 1 = rail good, 0 = rail off.
- err_clr, input, 1: clears the sticky error flag.
- pwr_en, output, 1: power-switch enable.
- iso, output, 1: isolation enable to the domain isolation cells; 1 = isolated.
- dom_reset, output, 1: domain reset, active-high.
- save, output, 1: one-cycle retention save strobe.
- restore, output, 1: one-cycle retention restore strobe.
- busy, output, 1: 1 in any transition state.
- on, output, 1: 1 only in state ON.
- err, output, 1: sticky ack-timeout flag.

Behaviour:
- Outputs:
  - All outputs are registered; each is a function of the current state only, plus `err`.
  - `busy` = state is neither OFF nor ON.
- Reset: state OFF. Output values are `pwr_en`=0, `iso`=1, `dom_reset`=1, `save`=0, `restore`=0, `busy`=0, `on`=0, `err`=0, counter=0.
- States and the outputs held in each (`pwr_en` / `iso` / `dom_reset`):
  - OFF: 0/1/1. If `pwr_req`=1, go to PU_SW next cycle.
  - PU_SW: 1/1/1. Waits for `pwr_ack`=1 sampled high, then goes to PU_RES (RET=1) or PU_RST (RET=0).
    - If `pwr_ack` is still 0 after TIMEOUT cycles in state, set `err`=1 and proceed as if acked.
  - PU_RES: 1/1/1, `restore`=1. Lasts exactly 1 cycle, then PU_RST.
  - PU_RST: 1/1/1. Lasts exactly RST_CYCLES cycles, then PU_ISO.
  - PU_ISO: 1/1/0. Lasts exactly ISO_CYCLES cycles, then ON.
  - ON: 1/0/0. If `pwr_req`=0, go to PD_ISO next cycle.
  - PD_ISO: 1/1/0. Lasts exactly ISO_CYCLES cycles, then PD_SAV (RET=1) or PD_RST (RET=0).
  - PD_SAV: 1/1/0, `save`=1. Lasts exactly 1 cycle, then PD_RST.
  - PD_RST: 1/1/1. Lasts exactly 1 cycle, then PD_SW.
  - PD_SW: 0/1/1. Waits for `pwr_ack`=0 sampled, with the same TIMEOUT/`err` rule, then OFF.
- Invariants:
  - `iso`=0 only in ON.
  - `dom_reset` changes only while `iso`=1.
  - `pwr_en` changes only while `iso`=1 and `dom_reset`=1.
- `pwr_req` is ignored in all transition states. A sequence always completes to OFF/ON; the request is then re-evaluated, so a toggled request yields a full opposite sequence.
- Counter:
  - Clears on every state change.
  - Saturates at all-ones and never wraps.
  - Timeout compare is counter == TIMEOUT-1 while in a wait state.
- `err`:
  - Set on any timeout.
  - Cleared by `err_clr` in any state.
  - Set has priority when both occur in the same cycle.
- `reset` mid-sequence: next cycle is OFF with reset values. No save strobe is issued.

Test Plan:
- Reset, then hold `pwr_req`=0 for 10 cycles -> outputs stay `pwr_en`=0, `iso`=1, `dom_reset`=1, `busy`=0, `on`=0.
- Power-up (ISO_CYCLES=4, RST_CYCLES=3, RET=1), `pwr_req`↑ sampled at cycle 0, `pwr_ack`↑ visible at cycle 3 -> expected sequence:
  - `pwr_en`=1 from cycle 1.
  - `restore`=1 in cycle 4 only.
  - `dom_reset`=0 from cycle 8.
  - `iso`=0 and `on`=1 from cycle 12.
- Power-down from ON, `pwr_req`↓ at cycle 0, ack falls 2 cycles after `pwr_en`↓ -> expected sequence:
  - `iso`=1 from cycle 1.
  - `save`=1 in cycle 5.
  - `dom_reset`=1 in cycle 6.
  - `pwr_en`=0 in cycle 7.
  - Stays in PD_SW until `pwr_ack`=0 is sampled, then OFF.
- `pwr_ack` stuck at 0 with TIMEOUT=8 -> `err`=1 after 8 cycles in PU_SW and the sequence continues to ON. `err_clr` pulse -> `err`=0.
- Toggle `pwr_req` 1→0 during PU_RST -> power-up completes to ON (1 cycle in ON), then a full power-down sequence to OFF.
- Assert `reset` during PU_ISO -> next cycle `iso`=1, `dom_reset`=1, `pwr_en`=0, state OFF. Separately, RET=0 -> `save`/`restore` never pulse and each sequence is 1 cycle shorter.
